axi_lite_to_reg: RTL and testbench

AXI4-Lite slave-side terminator that converts request/response structs into a single-outstanding register-bus access with a valid/ready handshake. It sits directly downstream of an AXI-Lite cut on the master port and feeds peripheral register files. The bridge serialises reads and writes, arbitrates round-robin between them, and bounds every register access with an optional timeout that returns SLVERR.

---
 rtl/axi_lite_to_reg.sv | 194 +++++++++++++++++++
 tb/tb_axi_lite_to_reg.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_to_reg.sv
// AXI4-Lite terminator that turns one AXI-Lite transaction at a time into a
// register-bus access with valid/ready handshake, round-robin R/W arbitration and timeout.
package axi_lite_to_reg_pkg;
  typedef struct packed {
    logic [31:0] addr;
  } aw_chan_t;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } w_chan_t;
  typedef struct packed {
    logic [1:0] resp;
  } b_chan_t;
  typedef struct packed {
    logic [31:0] addr;
  } ar_chan_t;
  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_chan_t;
  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;
  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    logic    ar_ready;
    r_chan_t r;
    logic    r_valid;
  } axi_resp_t;
endpackage

module axi_lite_to_reg #(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 0,
  parameter type axi_req_t  = axi_lite_to_reg_pkg::axi_req_t,
  parameter type axi_resp_t = axi_lite_to_reg_pkg::axi_resp_t,
  localparam int unsigned StrbWidth = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  axi_req_t             slv_req_i,
  output axi_resp_t            slv_resp_o,
  output logic                 reg_req_o,
  output logic                 reg_write_o,
  output logic [AddrWidth-1:0] reg_addr_o,
  output logic [DataWidth-1:0] reg_wdata_o,
  output logic [StrbWidth-1:0] reg_wstrb_o,
  input  logic                 reg_ready_i,
  input  logic [DataWidth-1:0] reg_rdata_i,
  input  logic                 reg_error_i
);

  localparam int unsigned CntWidth = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntWidth-1:0] CntMax =
    CntWidth'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
  localparam logic [AddrWidth-1:0] AddrMask = AddrWidth'(StrbWidth - 1);

  typedef enum logic [2:0] {IDLE, WR_ACC, RD_ACC, B_RESP, R_RESP} state_e;

  state_e               state_q, state_d;
  logic                 last_wr_q, last_wr_d;
  logic                 write_q, write_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [StrbWidth-1:0] wstrb_q, wstrb_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic                 req_q, req_d;
  logic                 b_valid_q, b_valid_d;
  logic                 r_valid_q, r_valid_d;

  logic wr_pend, rd_pend, grant_wr, grant_rd, timeout;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      last_wr_q <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      b_valid_q <= 1'b0;
      r_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      b_valid_q <= b_valid_d;
      r_valid_q <= r_valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cnt_d     = cnt_q;

    // A write needs both AW and W; a lone half is never taken.
    wr_pend  = slv_req_i.aw_valid && slv_req_i.w_valid;
    rd_pend  = slv_req_i.ar_valid;
    grant_wr = (state_q == IDLE) && wr_pend && (!rd_pend || !last_wr_q);
    grant_rd = (state_q == IDLE) && rd_pend && !grant_wr;
    timeout  = (TimeoutCycles != 0) && (cnt_q == CntMax);

    unique case (state_q)
      IDLE: begin
        if (grant_wr) begin
          state_d   = WR_ACC;
          last_wr_d = 1'b1;
          write_d   = 1'b1;
          addr_d    = AddrWidth'(slv_req_i.aw.addr) & ~AddrMask;
          wdata_d   = DataWidth'(slv_req_i.w.data);
          wstrb_d   = StrbWidth'(slv_req_i.w.strb);
          cnt_d     = '0;
        end else if (grant_rd) begin
          state_d   = RD_ACC;
          last_wr_d = 1'b0;
          write_d   = 1'b0;
          addr_d    = AddrWidth'(slv_req_i.ar.addr) & ~AddrMask;
          wdata_d   = '0;
          wstrb_d   = '0;
          cnt_d     = '0;
        end
      end
      WR_ACC, RD_ACC: begin
        // Ready takes priority over a timeout landing in the same cycle.
        if (reg_ready_i) begin
          err_d   = reg_error_i;
          rdata_d = write_q ? rdata_q : reg_rdata_i;
          state_d = write_q ? B_RESP : R_RESP;
        end else if (timeout) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = write_q ? B_RESP : R_RESP;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      B_RESP: if (slv_req_i.b_ready) state_d = IDLE;
      R_RESP: if (slv_req_i.r_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_d     = (state_d == WR_ACC) || (state_d == RD_ACC);
    b_valid_d = (state_d == B_RESP);
    r_valid_d = (state_d == R_RESP);

    slv_resp_o          = '0;
    slv_resp_o.aw_ready = grant_wr;
    slv_resp_o.w_ready  = grant_wr;
    slv_resp_o.ar_ready = grant_rd;
    slv_resp_o.b_valid  = b_valid_q;
    slv_resp_o.b.resp   = err_q ? 2'b10 : 2'b00;
    slv_resp_o.r_valid  = r_valid_q;
    slv_resp_o.r.data   = rdata_q;
    slv_resp_o.r.resp   = err_q ? 2'b10 : 2'b00;
  end

  assign reg_req_o   = req_q;
  assign reg_write_o = write_q;
  assign reg_addr_o  = addr_q;
  assign reg_wdata_o = wdata_q;
  assign reg_wstrb_o = wstrb_q;

endmodule

// File: tb/tb_axi_lite_to_reg.sv
// Scenario bench for axi_lite_to_reg: cycle-exact checks plus an expected-transaction queue.
module tb_axi_lite_to_reg;
  import axi_lite_to_reg_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  axi_req_t    req;
  axi_resp_t   resp;
  logic        reg_req, reg_write, reg_ready, reg_error;
  logic [31:0] reg_addr, reg_wdata, reg_rdata;
  logic [3:0]  reg_wstrb;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  axi_lite_to_reg #(
    .AddrWidth(32), .DataWidth(32), .TimeoutCycles(8)
  ) dut (
    .clk_i(clk), .rst_i(rst), .slv_req_i(req), .slv_resp_o(resp),
    .reg_req_o(reg_req), .reg_write_o(reg_write), .reg_addr_o(reg_addr),
    .reg_wdata_o(reg_wdata), .reg_wstrb_o(reg_wstrb), .reg_ready_i(reg_ready),
    .reg_rdata_i(reg_rdata), .reg_error_i(reg_error)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; reg_ready = 1'b0; reg_error = 1'b0; reg_rdata = '0;
    repeat (3) cyc();
    #1;
    total++;
    if (resp !== '0 || reg_req !== 1'b0 || reg_write !== 1'b0 || reg_addr !== '0 ||
        reg_wdata !== '0 || reg_wstrb !== '0) begin
      bad++;
      $display("FAIL reset_state: resp=%h req=%b wr=%b addr=%h wdata=%h strb=%h, required all 0",
               resp, reg_req, reg_write, reg_addr, reg_wdata, reg_wstrb);
    end
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    exp_t e;
    cyc();
    req.aw.addr = 32'h1003; req.aw_valid = 1'b1;
    req.w.data = 32'hDEADBEEF; req.w.strb = 4'hF; req.w_valid = 1'b1;
    req.b_ready = 1'b1; req.r_ready = 1'b1; reg_ready = 1'b1;
    exp_q.push_back('{is_wr: 1'b1, addr: 32'h1000, data: 32'hDEADBEEF, strb: 4'hF, resp: 2'b00});
    #1;
    total++;
    if (resp.aw_ready !== 1'b1 || resp.w_ready !== 1'b1 || resp.ar_ready !== 1'b0) begin
      bad++;
      $display("FAIL wr_accept: aw_rdy=%b w_rdy=%b ar_rdy=%b, required 1 1 0",
               resp.aw_ready, resp.w_ready, resp.ar_ready);
    end
    cyc();
    req.aw_valid = 1'b0; req.w_valid = 1'b0;
    #1;
    total++;
    if (reg_req !== 1'b1 || reg_write !== 1'b1 || reg_addr !== exp_q[0].addr ||
        reg_wdata !== exp_q[0].data || reg_wstrb !== exp_q[0].strb || resp.b_valid !== 1'b0) begin
      bad++;
      $display("FAIL wr_regbus: req=%b wr=%b addr=%h data=%h strb=%h bv=%b, required 1 1 %h %h %h 0",
               reg_req, reg_write, reg_addr, reg_wdata, reg_wstrb, resp.b_valid,
               exp_q[0].addr, exp_q[0].data, exp_q[0].strb);
    end
    cyc();
    #1;
    e = exp_q.pop_front();
    $display("txn write addr=%h data=%h resp=%b", e.addr, e.data, resp.b.resp);
    total++;
    if (resp.b_valid !== 1'b1 || resp.b.resp !== e.resp || reg_req !== 1'b0) begin
      bad++;
      $display("FAIL wr_bresp: bv=%b resp=%b req=%b, required 1 %b 0",
               resp.b_valid, resp.b.resp, reg_req, e.resp);
    end
    cyc();
    #1;
    total++;
    if (resp.b_valid !== 1'b0) begin
      bad++;
      $display("FAIL wr_bdone: bv=%b, required 0", resp.b_valid);
    end
  endtask

  task automatic test_single_read();
    exp_t e;
    cyc();
    req.ar.addr = 32'h20; req.ar_valid = 1'b1; reg_ready = 1'b0; reg_rdata = '0;
    exp_q.push_back('{is_wr: 1'b0, addr: 32'h20, data: 32'h12345678, strb: 4'h0, resp: 2'b00});
    #1;
    total++;
    if (resp.ar_ready !== 1'b1 || resp.aw_ready !== 1'b0) begin
      bad++;
      $display("FAIL rd_accept: ar_rdy=%b aw_rdy=%b, required 1 0", resp.ar_ready, resp.aw_ready);
    end
    for (int i = 1; i <= 4; i++) begin
      cyc();
      if (i == 1) req.ar_valid = 1'b0;
      if (i == 4) begin reg_ready = 1'b1; reg_rdata = 32'h12345678; end
      #1;
      total++;
      if (reg_req !== 1'b1 || reg_write !== 1'b0 || reg_addr !== 32'h20 ||
          reg_wstrb !== 4'h0 || resp.r_valid !== 1'b0) begin
        bad++;
        $display("FAIL rd_hold%0d: req=%b wr=%b addr=%h strb=%h rv=%b, required 1 0 00000020 0 0",
                 i, reg_req, reg_write, reg_addr, reg_wstrb, resp.r_valid);
      end
    end
    cyc();
    reg_ready = 1'b0; reg_rdata = '0;
    #1;
    e = exp_q.pop_front();
    $display("txn read addr=%h data=%h resp=%b", e.addr, resp.r.data, resp.r.resp);
    total++;
    if (resp.r_valid !== 1'b1 || resp.r.data !== e.data || resp.r.resp !== e.resp || reg_req !== 1'b0) begin
      bad++;
      $display("FAIL rd_rresp: rv=%b data=%h resp=%b req=%b, required 1 %h %b 0",
               resp.r_valid, resp.r.data, resp.r.resp, reg_req, e.data, e.resp);
    end
    cyc();
    #1;
    total++;
    if (resp.r_valid !== 1'b0) begin
      bad++;
      $display("FAIL rd_rdone: rv=%b, required 0", resp.r_valid);
    end
  endtask

  task automatic test_arbitration();
    exp_t e;
    logic model_last = 1'b0;
    logic exp_dir;
    int   grants = 0;
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    req.aw.addr = 32'h100; req.w.data = 32'hCAFE0001; req.w.strb = 4'hF;
    req.ar.addr = 32'h200; req.aw_valid = 1'b1; req.w_valid = 1'b1; req.ar_valid = 1'b1;
    req.b_ready = 1'b1; req.r_ready = 1'b1; reg_ready = 1'b1; reg_rdata = 32'hA5A50000;
    for (int c = 0; c < 40 && (grants < 6 || exp_q.size() != 0); c++) begin
      if (grants >= 6) begin
        req.aw_valid = 1'b0; req.w_valid = 1'b0; req.ar_valid = 1'b0;
      end
      #1;
      if (resp.aw_ready || resp.ar_ready) begin
        exp_dir    = !model_last;
        model_last = exp_dir;
        total++;
        if ((resp.aw_ready && resp.ar_ready) || resp.aw_ready !== exp_dir) begin
          bad++;
          $display("FAIL arb_grant%0d: aw_rdy=%b ar_rdy=%b, required write_grant=%b",
                   grants, resp.aw_ready, resp.ar_ready, exp_dir);
        end
        exp_q.push_back('{is_wr: exp_dir, addr: exp_dir ? 32'h100 : 32'h200,
                          data: exp_dir ? 32'hCAFE0001 : 32'hA5A50000,
                          strb: exp_dir ? 4'hF : 4'h0, resp: 2'b00});
        grants++;
      end
      if (resp.b_valid || resp.r_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL arb_unexpected: bv=%b rv=%b, required no response", resp.b_valid, resp.r_valid);
        end else begin
          e = exp_q.pop_front();
          $display("txn %s addr=%h resp=%b", e.is_wr ? "write" : "read", e.addr,
                   e.is_wr ? resp.b.resp : resp.r.resp);
          if (resp.b_valid !== e.is_wr || resp.r_valid !== !e.is_wr ||
              (!e.is_wr && resp.r.data !== e.data) ||
              (e.is_wr ? resp.b.resp : resp.r.resp) !== e.resp) begin
            bad++;
            $display("FAIL arb_resp: bv=%b rv=%b rdata=%h, required bv=%b rv=%b rdata=%h",
                     resp.b_valid, resp.r_valid, resp.r.data, e.is_wr, !e.is_wr, e.data);
          end
        end
      end
      cyc();
    end
    total++;
    if (grants != 6 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL arb_budget: grants=%0d pending=%0d, required 6 and 0", grants, exp_q.size());
      exp_q.delete();
    end
    req.aw_valid = 1'b0; req.w_valid = 1'b0; req.ar_valid = 1'b0;
  endtask

  task automatic test_timeout();
    exp_t e;
    cyc();
    req.ar.addr = 32'h44; req.ar_valid = 1'b1; req.r_ready = 1'b1;
    reg_ready = 1'b0; reg_rdata = 32'hFFFFFFFF;
    exp_q.push_back('{is_wr: 1'b0, addr: 32'h44, data: 32'h0, strb: 4'h0, resp: 2'b10});
    #1;
    total++;
    if (resp.ar_ready !== 1'b1) begin
      bad++;
      $display("FAIL to_accept: ar_rdy=%b, required 1", resp.ar_ready);
    end
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (i == 1) req.ar_valid = 1'b0;
      #1;
      total++;
      if (reg_req !== 1'b1 || resp.r_valid !== 1'b0) begin
        bad++;
        $display("FAIL to_wait%0d: req=%b rv=%b, required 1 0", i, reg_req, resp.r_valid);
      end
    end
    cyc();
    #1;
    e = exp_q.pop_front();
    $display("txn read addr=%h data=%h resp=%b (timeout)", e.addr, resp.r.data, resp.r.resp);
    total++;
    if (reg_req !== 1'b0 || resp.r_valid !== 1'b1 || resp.r.data !== e.data || resp.r.resp !== e.resp) begin
      bad++;
      $display("FAIL to_resp: req=%b rv=%b data=%h resp=%b, required 0 1 %h %b",
               reg_req, resp.r_valid, resp.r.data, resp.r.resp, e.data, e.resp);
    end
    cyc();
    reg_rdata = '0;
  endtask

  task automatic test_error_backpressure();
    exp_t e;
    cyc();
    req.aw.addr = 32'h08; req.w.data = 32'h55; req.w.strb = 4'h3;
    req.aw_valid = 1'b1; req.w_valid = 1'b1; req.b_ready = 1'b0;
    reg_ready = 1'b1; reg_error = 1'b1;
    exp_q.push_back('{is_wr: 1'b1, addr: 32'h08, data: 32'h55, strb: 4'h3, resp: 2'b10});
    #1;
    total++;
    if (resp.aw_ready !== 1'b1 || resp.w_ready !== 1'b1) begin
      bad++;
      $display("FAIL err_accept: aw_rdy=%b w_rdy=%b, required 1 1", resp.aw_ready, resp.w_ready);
    end
    cyc();
    #1;
    total++;
    if (reg_req !== 1'b1 || resp.aw_ready !== 1'b0) begin
      bad++;
      $display("FAIL err_acc: req=%b aw_rdy=%b, required 1 0", reg_req, resp.aw_ready);
    end
    for (int i = 2; i <= 7; i++) begin
      cyc();
      if (i == 2) reg_error = 1'b0;
      if (i == 7) req.b_ready = 1'b1;
      #1;
      total++;
      if (resp.b_valid !== 1'b1 || resp.b.resp !== 2'b10 ||
          resp.aw_ready !== 1'b0 || resp.w_ready !== 1'b0) begin
        bad++;
        $display("FAIL err_hold%0d: bv=%b resp=%b aw_rdy=%b w_rdy=%b, required 1 10 0 0",
                 i, resp.b_valid, resp.b.resp, resp.aw_ready, resp.w_ready);
      end
    end
    e = exp_q.pop_front();
    $display("txn write addr=%h data=%h resp=%b", e.addr, e.data, resp.b.resp);
    cyc();
    exp_q.push_back('{is_wr: 1'b1, addr: 32'h08, data: 32'h55, strb: 4'h3, resp: 2'b00});
    #1;
    total++;
    if (resp.aw_ready !== 1'b1 || resp.w_ready !== 1'b1 || resp.b_valid !== 1'b0) begin
      bad++;
      $display("FAIL err_reaccept: aw_rdy=%b w_rdy=%b bv=%b, required 1 1 0",
               resp.aw_ready, resp.w_ready, resp.b_valid);
    end
    cyc();
    req.aw_valid = 1'b0; req.w_valid = 1'b0;
    #1;
    total++;
    if (reg_req !== 1'b1 || reg_addr !== exp_q[0].addr || reg_wdata !== exp_q[0].data ||
        reg_wstrb !== exp_q[0].strb) begin
      bad++;
      $display("FAIL err_second_acc: req=%b addr=%h data=%h strb=%h, required 1 %h %h %h",
               reg_req, reg_addr, reg_wdata, reg_wstrb, exp_q[0].addr, exp_q[0].data, exp_q[0].strb);
    end
    cyc();
    #1;
    e = exp_q.pop_front();
    $display("txn write addr=%h data=%h resp=%b", e.addr, e.data, resp.b.resp);
    total++;
    if (resp.b_valid !== 1'b1 || resp.b.resp !== e.resp) begin
      bad++;
      $display("FAIL err_second_b: bv=%b resp=%b, required 1 %b", resp.b_valid, resp.b.resp, e.resp);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    cyc();
    req.ar.addr = 32'h30; req.ar_valid = 1'b1; req.r_ready = 1'b1; reg_ready = 1'b0;
    exp_q.push_back('{is_wr: 1'b0, addr: 32'h30, data: 32'h0, strb: 4'h0, resp: 2'b00});
    #1;
    total++;
    if (resp.ar_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_accept: ar_rdy=%b, required 1", resp.ar_ready);
    end
    cyc();
    req.ar_valid = 1'b0;
    #1;
    total++;
    if (reg_req !== 1'b1 || reg_addr !== 32'h30) begin
      bad++;
      $display("FAIL rst_pre: req=%b addr=%h, required 1 00000030", reg_req, reg_addr);
    end
    cyc();
    rst = 1'b1;
    cyc();
    #1;
    total++;
    if (reg_req !== 1'b0 || resp !== '0 || reg_addr !== '0 || reg_write !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid: req=%b resp=%h addr=%h wr=%b, required all 0",
               reg_req, resp, reg_addr, reg_write);
    end
    exp_q.delete();
    $display("txn read addr=00000030 discarded by reset");
    cyc();
    rst = 1'b0;
    req.aw.addr = 32'h40; req.aw_valid = 1'b1; req.w_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      total++;
      if (resp.aw_ready !== 1'b0 || resp.w_ready !== 1'b0 || reg_req !== 1'b0) begin
        bad++;
        $display("FAIL aw_alone%0d: aw_rdy=%b w_rdy=%b req=%b, required 0 0 0",
                 i, resp.aw_ready, resp.w_ready, reg_req);
      end
      cyc();
    end
    req.aw_valid = 1'b0;
    req.ar.addr = 32'h30; req.ar_valid = 1'b1; reg_ready = 1'b1; reg_rdata = 32'h0BADF00D;
    exp_q.push_back('{is_wr: 1'b0, addr: 32'h30, data: 32'h0BADF00D, strb: 4'h0, resp: 2'b00});
    #1;
    total++;
    if (resp.ar_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_idle: ar_rdy=%b, required 1", resp.ar_ready);
    end
    cyc();
    req.ar_valid = 1'b0;
    cyc();
    #1;
    e = exp_q.pop_front();
    $display("txn read addr=%h data=%h resp=%b", e.addr, resp.r.data, resp.r.resp);
    total++;
    if (resp.r_valid !== 1'b1 || resp.r.data !== e.data || resp.r.resp !== e.resp) begin
      bad++;
      $display("FAIL rst_after_read: rv=%b data=%h resp=%b, required 1 %h %b",
               resp.r_valid, resp.r.data, resp.r.resp, e.data, e.resp);
    end
    cyc();
    reg_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_arbitration();
    test_timeout();
    test_error_backpressure();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover: pending=%0d, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
